// File: rtl/sdp_request_gen.sv
// Turns a start address plus alternating consecutive/jump word counts into
// one DRAM line request per distinct line touched, with stream framing.
module sdp_request_gen #(
  parameter int NUM_CHANNELS   = 4,
  parameter int WORDS_PER_LINE = 8,
  parameter int BANK_W         = 2,
  parameter int PAGE_W         = 4,
  parameter int CJ_W           = 12,
  parameter int ADDR_W         = $clog2(WORDS_PER_LINE) + $clog2(NUM_CHANNELS) + BANK_W + PAGE_W
) (
  input  logic                              clk,
  input  logic                              reset_poweron,
  input  logic                              cfg_valid,
  input  logic [ADDR_W-1:0]                 cfg_addr,
  output logic                              cfg_ready,
  input  logic                              cj_valid,
  input  logic [1:0]                        cj_cntl,
  input  logic [CJ_W-1:0]                   cj_value,
  output logic                              cj_ready,
  output logic                              req_valid,
  output logic [1:0]                        req_cntl,
  output logic [$clog2(NUM_CHANNELS)-1:0]   req_channel,
  output logic [BANK_W-1:0]                 req_bank,
  output logic [PAGE_W-1:0]                 req_page,
  output logic [$clog2(WORDS_PER_LINE)-1:0] req_word,
  input  logic                              req_ready,
  output logic                              complete,
  output logic [15:0]                       lines_issued,
  output logic                              err
);

  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int LW = ADDR_W - WW;

  typedef enum logic [1:0] {IDLE, WAIT_CJ, CONS, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [LW-1:0]     cur_line, last_line;
  logic [WW-1:0]     cur_word;
  logic [CJ_W-1:0]   cur_rem;
  logic              cur_last, entry_eom, som_pend, last_valid, expect_jump;
  logic [1:0]        cntl_q;

  logic [ADDR_W-1:0] ptr_sum;
  logic [LW-1:0]     in_line, ld_line;
  logic [WW-1:0]     in_word, ld_word;
  logic [CJ_W-1:0]   in_room, cur_room, ld_rem, ld_room;
  logic              in_skip, in_none, ld_last, ld_eom, ld_som, req_fire;
  logic              cj_som_unused;

  assign cj_som_unused = cj_cntl[0];
  assign ptr_sum  = ptr + ADDR_W'(cj_value);
  assign in_word  = ptr[WW-1:0];
  assign in_line  = ptr[ADDR_W-1:WW];
  assign in_room  = CJ_W'(WORDS_PER_LINE) - CJ_W'(in_word);
  assign cur_room = CJ_W'(WORDS_PER_LINE) - CJ_W'(cur_word);
  // Only the first line of an entry can repeat the previously issued line.
  assign in_skip  = last_valid && (in_line == last_line);
  assign in_none  = (cj_value == '0) || (in_skip && (cj_value <= in_room));
  assign req_fire = (state == CONS) && req_ready;

  // Next request to present: first of a new entry, or the line after the current one.
  always_comb begin
    ld_line = cur_line + LW'(1);
    ld_word = '0;
    ld_rem  = cur_rem - cur_room;
    ld_eom  = entry_eom;
    ld_som  = 1'b0;
    if (state == WAIT_CJ) begin
      if (in_skip) begin
        ld_line = in_line + LW'(1);
        ld_rem  = cj_value - in_room;
      end else begin
        ld_line = in_line;
        ld_word = in_word;
        ld_rem  = cj_value;
      end
      ld_eom = cj_cntl[1];
      ld_som = som_pend;
    end
    ld_room = CJ_W'(WORDS_PER_LINE) - CJ_W'(ld_word);
    ld_last = ld_rem <= ld_room;
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) state <= IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cfg_valid) state_nx = WAIT_CJ;
      WAIT_CJ: if (cj_valid) begin
        if (expect_jump || in_none) state_nx = cj_cntl[1] ? DONE : WAIT_CJ;
        else                        state_nx = CONS;
      end
      CONS:    if (req_ready && cur_last) state_nx = entry_eom ? DONE : WAIT_CJ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE) && !reset_poweron;
    cj_ready  = (state == WAIT_CJ);
    req_valid = (state == CONS);
    complete  = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      ptr          <= '0;
      cur_line     <= '0;
      cur_word     <= '0;
      cur_rem      <= '0;
      cur_last     <= 1'b0;
      cntl_q       <= '0;
      entry_eom    <= 1'b0;
      som_pend     <= 1'b0;
      last_line    <= '0;
      last_valid   <= 1'b0;
      expect_jump  <= 1'b0;
      lines_issued <= '0;
      err          <= 1'b0;
    end else begin
      if (state == IDLE && cfg_valid) begin
        ptr          <= cfg_addr;
        lines_issued <= '0;
        last_valid   <= 1'b0;
        expect_jump  <= 1'b0;
        som_pend     <= 1'b1;
      end
      if (state == WAIT_CJ && cj_valid) begin
        expect_jump <= !expect_jump;
        ptr         <= ptr_sum;
        if (expect_jump) begin
          if (cj_cntl[1]) err <= 1'b1;
        end else begin
          entry_eom <= cj_cntl[1];
        end
      end
      if (req_fire) begin
        if (lines_issued != '1) lines_issued <= lines_issued + 16'd1;
        last_line  <= cur_line;
        last_valid <= 1'b1;
        som_pend   <= 1'b0;
      end
      if ((state == WAIT_CJ && cj_valid && !expect_jump && !in_none) ||
          (req_fire && !cur_last)) begin
        cur_line <= ld_line;
        cur_word <= ld_word;
        cur_rem  <= ld_rem;
        cur_last <= ld_last;
        cntl_q   <= {ld_eom && ld_last, ld_som};
      end
    end
  end

  assign req_cntl    = cntl_q;
  assign req_channel = cur_line[CW-1:0];
  assign req_bank    = cur_line[CW +: BANK_W];
  assign req_page    = cur_line[CW+BANK_W +: PAGE_W];
  assign req_word    = cur_word;

endmodule

// File: tb/tb_sdp_request_gen.sv
// Directed bench for sdp_request_gen at default parameters (ADDR_W=11).
module tb_sdp_request_gen;

  logic        clk = 1'b0;
  logic        reset_poweron;
  logic        cfg_valid;
  logic [10:0] cfg_addr;
  logic        cfg_ready;
  logic        cj_valid;
  logic [1:0]  cj_cntl;
  logic [11:0] cj_value;
  logic        cj_ready;
  logic        req_valid;
  logic [1:0]  req_cntl;
  logic [1:0]  req_channel;
  logic [1:0]  req_bank;
  logic [3:0]  req_page;
  logic [2:0]  req_word;
  logic        req_ready;
  logic        complete;
  logic [15:0] lines_issued;
  logic        err;

  int checks = 0;
  int failures = 0;

  sdp_request_gen #(
    .NUM_CHANNELS(4), .WORDS_PER_LINE(8), .BANK_W(2), .PAGE_W(4), .CJ_W(12)
  ) dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_ready(cfg_ready),
    .cj_valid(cj_valid), .cj_cntl(cj_cntl), .cj_value(cj_value), .cj_ready(cj_ready),
    .req_valid(req_valid), .req_cntl(req_cntl), .req_channel(req_channel),
    .req_bank(req_bank), .req_page(req_page), .req_word(req_word), .req_ready(req_ready),
    .complete(complete), .lines_issued(lines_issued), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [10:0] a);
    chk("cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_cj(input logic [1:0] c, input logic [11:0] v);
    chk("cj_ready", 32'(cj_ready), 32'd1);
    cj_valid = 1'b1;
    cj_cntl  = c;
    cj_value = v;
    @(negedge clk);
    cj_valid = 1'b0;
  endtask

  task automatic show_req(input string tag, input int ch, input int bk, input int pg,
                          input int wd, input int cn);
    logic [12:0] e;
    e = {2'(ch), 2'(bk), 4'(pg), 3'(wd), 2'(cn)};
    chk({tag, "_valid"}, 32'(req_valid), 32'd1);
    chk({tag, "_fields"}, 32'({req_channel, req_bank, req_page, req_word, req_cntl}), 32'(e));
  endtask

  task automatic expect_req(input string tag, input int ch, input int bk, input int pg,
                            input int wd, input int cn);
    show_req(tag, ch, bk, pg, wd, cn);
    @(negedge clk);
  endtask

  task automatic expect_done(input string tag, input int lines);
    chk({tag, "_complete"}, 32'(complete), 32'd1);
    chk({tag, "_noreq"}, 32'(req_valid), 32'd0);
    chk({tag, "_lines"}, 32'(lines_issued), 32'(lines));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(complete), 32'd0);
  endtask

  initial begin
    reset_poweron = 1'b1;
    cfg_valid = 1'b0; cfg_addr = '0;
    cj_valid = 1'b0; cj_cntl = '0; cj_value = '0;
    req_ready = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_outputs", 32'({req_valid, cj_ready, complete, err, req_cntl, req_word}), 32'd0);
    chk("rst_lines", 32'(lines_issued), 32'd0);
    reset_poweron = 1'b0;
    #1;
    chk("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);

    // two full lines from address 0
    do_cfg(11'h000);
    do_cj(2'b11, 12'd16);
    expect_req("r21a", 0, 0, 0, 0, 1);
    expect_req("r21b", 1, 0, 0, 0, 2);
    expect_done("r21", 2);

    // unaligned start, then jump 0 and empty EOM entry
    do_cfg(11'h005);
    do_cj(2'b01, 12'd4);
    expect_req("r22a", 0, 0, 0, 5, 1);
    expect_req("r22b", 1, 0, 0, 0, 0);
    do_cj(2'b00, 12'd0);
    chk("r22_jump_noreq", 32'(req_valid), 32'd0);
    do_cj(2'b10, 12'd0);
    expect_done("r22", 2);

    // second entry lands in the same line and is deduplicated
    do_cfg(11'h000);
    do_cj(2'b01, 12'd4);
    expect_req("r23a", 0, 0, 0, 0, 1);
    do_cj(2'b00, 12'd2);
    do_cj(2'b10, 12'd2);
    expect_done("r23", 1);

    // address wrap from the top word
    do_cfg(11'h7FF);
    do_cj(2'b11, 12'd2);
    expect_req("r24a", 3, 3, 15, 7, 1);
    expect_req("r24b", 0, 0, 0, 0, 2);
    expect_done("r24", 2);

    // backpressure for three cycles on the middle line
    do_cfg(11'h000);
    do_cj(2'b11, 12'd24);
    expect_req("r25a", 0, 0, 0, 0, 1);
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      show_req("r25_stall", 1, 0, 0, 0, 0);
      @(negedge clk);
    end
    req_ready = 1'b1;
    expect_req("r25b", 1, 0, 0, 0, 0);
    expect_req("r25c", 2, 0, 0, 0, 2);
    expect_done("r25", 3);

    // EOM on a jump entry
    chk("err_before", 32'(err), 32'd0);
    do_cfg(11'h000);
    do_cj(2'b01, 12'd4);
    expect_req("r26a", 0, 0, 0, 0, 1);
    do_cj(2'b10, 12'd0);
    chk("err_set", 32'(err), 32'd1);
    expect_done("r26", 1);
    do_cfg(11'h010);
    chk("err_sticky", 32'(err), 32'd1);

    // reset while a request is pending
    do_cj(2'b01, 12'd16);
    show_req("r26_pending", 2, 0, 0, 0, 1);
    reset_poweron = 1'b1;
    #1;
    chk("midrst_outputs", 32'({req_valid, cfg_ready, cj_ready, complete, err}), 32'd0);
    chk("midrst_req", 32'({req_channel, req_bank, req_page, req_word, req_cntl}), 32'd0);
    chk("midrst_lines", 32'(lines_issued), 32'd0);
    @(negedge clk);
    reset_poweron = 1'b0;
    #1;
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    chk("midrst_no_complete", 32'({complete, req_valid}), 32'd0);

    // single-line stream after reset
    do_cfg(11'h000);
    do_cj(2'b11, 12'd1);
    expect_req("single", 0, 0, 0, 0, 3);
    expect_done("single", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
